uart_rx_deserializer: RTL and testbench

//  Serial-to-parallel UART receiver; consumes the line driven by the UART transmitter's Tx_out.

---
 rtl/uart_rx_deserializer.sv | 156 +++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start, WORD_LENGHT data bits LSB first, one stop bit.
// The line is resynchronised, sampled at mid-bit, and each word is held in a
// one-entry register drained by a valid/ack handshake.
module uart_rx_deserializer #(
  parameter int WORD_LENGHT = 8,
  parameter int FREQUENCY   = 10,
  parameter int BAUDRATE    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   Rx_in,
  output logic [WORD_LENGHT-1:0] Rx_data,
  output logic                   Rx_valid,
  input  logic                   Rx_ack,
  output logic                   Rx_frame_err,
  output logic                   Rx_overrun,
  output logic                   Rx_busy
);

  localparam int CLKS_PER_BIT = FREQUENCY / BAUDRATE;
  localparam int HALF         = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT);
  localparam int IW           = (WORD_LENGHT > 1) ? $clog2(WORD_LENGHT) : 1;

  localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WORD_LENGHT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WORD_LENGHT-1:0] shreg_q, shreg_d;
  logic [WORD_LENGHT-1:0] data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   rx_meta_q, rx_s_q;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= Rx_in;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Next-state: bit timing, shifting, commit into the holding register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    // A pop empties the register unless a commit below refills it.
    if (valid_q && Rx_ack) valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          idx_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d          = '0;
          shreg_d[idx_q] = rx_s_q;
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = IDLE;
            if (!valid_q || Rx_ack) begin
              data_d  = shreg_q;
              valid_d = 1'b1;
            end else begin
              // Consumer has not popped: keep the old word, drop the new one.
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BREAK: begin
        // Hold off new starts until the line returns to idle.
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign Rx_data      = data_q;
  assign Rx_valid     = valid_q;
  assign Rx_frame_err = ferr_q;
  assign Rx_overrun   = ovr_q;
  assign Rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed corner sequences, a vector table,
// and random frames checked against a word-level holding-register model.
module tb_uart_rx_deserializer;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       Rx_in;
  logic [7:0] Rx_data;
  logic       Rx_valid;
  logic       Rx_ack;
  logic       Rx_frame_err;
  logic       Rx_overrun;
  logic       Rx_busy;

  uart_rx_deserializer #(.WORD_LENGHT(8), .FREQUENCY(10), .BAUDRATE(1)) dut (
    .clk(clk), .rst(rst), .Rx_in(Rx_in), .Rx_data(Rx_data), .Rx_valid(Rx_valid),
    .Rx_ack(Rx_ack), .Rx_frame_err(Rx_frame_err), .Rx_overrun(Rx_overrun),
    .Rx_busy(Rx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Free-running cycle count and pulse monitor (sole writer of its variables).
  int   cyc = 0;
  int   ferr_cnt = 0, ovr_cnt = 0, busy_rises = 0, pulse_bad = 0;
  int   start_cyc = 0, vld_cyc = 0;
  logic prev_busy = 1'b0, prev_valid = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (Rx_frame_err) ferr_cnt++;
    if (Rx_overrun)   ovr_cnt++;
    if ((Rx_frame_err && Rx_overrun) || (Rx_frame_err && prev_ferr) ||
        (Rx_overrun && prev_ovr)) pulse_bad++;
    if (Rx_busy && !prev_busy) begin busy_rises++; start_cyc = cyc; end
    if (Rx_valid && !prev_valid) vld_cyc = cyc;
    prev_busy  = Rx_busy;
    prev_valid = Rx_valid;
    prev_ferr  = Rx_frame_err;
    prev_ovr   = Rx_overrun;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Start bit plus data bits; caller owns the stop bit. Entered at a negedge.
  task automatic send_word(input logic [7:0] d);
    Rx_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx_in = d[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_word(d);
    Rx_in = stop_bit;
    repeat (CPB) @(negedge clk);
    Rx_in = 1'b1;
  endtask

  task automatic pop();
    Rx_ack = 1'b1;
    @(negedge clk);
    Rx_ack = 1'b0;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    logic       ack;
    logic       ev;
    logic [7:0] ed;
    int         ef;
    int         eo;
  } vec_t;

  vec_t tbl[7];

  // Word-level reference: one holding slot, pops before each frame.
  logic       m_valid;
  logic [7:0] m_data;

  initial begin
    int f0, o0, b0;
    logic [7:0] d;
    logic       st, ak;
    int         gap, ef, eo;

    tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 0};
    tbl[1] = '{8'hC3, 1'b1, 1'b0, 1'b1, 8'h3C, 0, 1};
    tbl[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 1, 0};
    tbl[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 0, 0};
    tbl[4] = '{8'h81, 1'b0, 1'b1, 1'b0, 8'h00, 1, 0};
    tbl[5] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'h55, 0, 0};
    tbl[6] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 0, 0};

    // Reset
    rst = 1'b1; Rx_in = 1'b1; Rx_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_data",  Rx_data, 0);
    chk("rst_valid", Rx_valid, 0);
    chk("rst_ferr",  Rx_frame_err, 0);
    chk("rst_ovr",   Rx_overrun, 0);
    chk("rst_busy",  Rx_busy, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean frame: valid 95 cycles after entering START
    f0 = ferr_cnt; o0 = ovr_cnt;
    send_frame(8'h64, 1'b1);
    repeat (5) @(negedge clk);
    chk("t2_valid",   Rx_valid, 1);
    chk("t2_data",    Rx_data, 8'h64);
    chk("t2_latency", vld_cyc - start_cyc, 95);
    chk("t2_errs",    (ferr_cnt - f0) + (ovr_cnt - o0), 0);
    pop();
    chk("t2_ack_clears", Rx_valid, 0);

    // Start glitch
    b0 = busy_rises; f0 = ferr_cnt;
    Rx_in = 1'b0;
    repeat (3) @(negedge clk);
    Rx_in = 1'b1;
    repeat (20) @(negedge clk);
    chk("t3_entered_start", busy_rises - b0, 1);
    chk("t3_busy",  Rx_busy, 0);
    chk("t3_valid", Rx_valid, 0);
    chk("t3_ferr",  ferr_cnt - f0, 0);

    // Stop bit low, line held low: BREAK until released
    f0 = ferr_cnt;
    send_word(8'hA5);
    Rx_in = 1'b0;
    repeat (CPB + 30) @(negedge clk);
    chk("t4_ferr",       ferr_cnt - f0, 1);
    chk("t4_valid",      Rx_valid, 0);
    chk("t4_busy_break", Rx_busy, 1);
    Rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t4_busy_idle",  Rx_busy, 0);

    // Back-to-back without pop: overrun, first word kept
    o0 = ovr_cnt;
    send_frame(8'h64, 1'b1);
    send_frame(8'h73, 1'b1);
    repeat (5) @(negedge clk);
    chk("t5_ovr",   ovr_cnt - o0, 1);
    chk("t5_data",  Rx_data, 8'h64);
    chk("t5_valid", Rx_valid, 1);
    pop();
    repeat (5) @(negedge clk);

    // Back-to-back with pop landing on the second commit edge
    o0 = ovr_cnt;
    fork
      begin
        send_frame(8'h64, 1'b1);
        send_frame(8'h73, 1'b1);
      end
      begin
        repeat (100 + 97) @(negedge clk);
        Rx_ack = 1'b1;
        @(negedge clk);
        Rx_ack = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    chk("t5b_ovr",   ovr_cnt - o0, 0);
    chk("t5b_data",  Rx_data, 8'h73);
    chk("t5b_valid", Rx_valid, 1);

    // Reset mid-DATA
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy",  Rx_busy, 0);
        chk("t6_rst_valid", Rx_valid, 0);
        rst = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("t6_no_valid", Rx_valid, 0);
    chk("t6_busy",     Rx_busy, 0);
    send_frame(8'h0F, 1'b1);
    repeat (5) @(negedge clk);
    chk("t6_valid", Rx_valid, 1);
    chk("t6_data",  Rx_data, 8'h0F);
    pop();
    repeat (5) @(negedge clk);

    // Vector table
    for (int i = 0; i < 7; i++) begin
      f0 = ferr_cnt; o0 = ovr_cnt;
      if (tbl[i].ack) pop();
      send_frame(tbl[i].d, tbl[i].stop);
      repeat (3 * CPB) @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), Rx_valid, tbl[i].ev);
      if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), Rx_data, tbl[i].ed);
      chk($sformatf("tbl%0d_ferr", i), ferr_cnt - f0, tbl[i].ef);
      chk($sformatf("tbl%0d_ovr", i),  ovr_cnt - o0, tbl[i].eo);
    end

    // Random frames against the word-level model
    m_valid = 1'b1;
    m_data  = 8'hAA;
    for (int n = 0; n < 40; n++) begin
      d   = 8'($urandom);
      st  = ($urandom_range(0, 3) != 0);
      ak  = 1'($urandom);
      gap = st ? $urandom_range(0, 2 * CPB) : $urandom_range(1, 2 * CPB);
      ef = 0; eo = 0;
      if (ak) m_valid = 1'b0;
      if (!st)          ef = 1;
      else if (m_valid) eo = 1;
      else begin m_valid = 1'b1; m_data = d; end
      f0 = ferr_cnt; o0 = ovr_cnt;
      if (ak) pop();
      send_frame(d, st);
      chk($sformatf("rnd%0d_valid", n), Rx_valid, m_valid);
      if (m_valid) chk($sformatf("rnd%0d_data", n), Rx_data, m_data);
      chk($sformatf("rnd%0d_ferr", n), ferr_cnt - f0, ef);
      chk($sformatf("rnd%0d_ovr", n),  ovr_cnt - o0, eo);
      repeat (gap) @(negedge clk);
    end

    repeat (3 * CPB) @(negedge clk);
    chk("pulse_shape", pulse_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
